// File: rtl/core_ctrl_pkg.sv
// Shared types for the core run/halt controller.
//   ctrl_state_e : sequencer states (idle, boot, run, single-step, halt)
//   halt_cause_e : encoded reason the core last stopped, as seen on halt_cause
package core_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StBoot = 3'd1,
      StRun  = 3'd2,
      StStep = 3'd3,
      StHalt = 3'd4
   } ctrl_state_e;

   typedef enum logic [2:0] {
      CauseNone   = 3'd0,
      CauseEcall  = 3'd1,
      CauseEbreak = 3'd2,
      CauseExt    = 3'd3,
      CauseStep   = 3'd4
   } halt_cause_e;

   localparam logic [2:0] CAUSE_NONE   = 3'd0;
   localparam logic [2:0] CAUSE_ECALL  = 3'd1;
   localparam logic [2:0] CAUSE_EBREAK = 3'd2;
   localparam logic [2:0] CAUSE_EXT    = 3'd3;
   localparam logic [2:0] CAUSE_STEP   = 3'd4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset, clears the count
//   clr : synchronous clear (wins over inc)
//   inc : increment by one; holds at all-ones instead of wrapping
//   q   : current count
module sat_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (inc && (q_q != {W{1'b1}})) begin
         q_d = q_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/core_run_ctrl.sv
// Run/halt sequencer for the single-cycle core. Boots the core out of reset, gates execution
// through core_en, stops on Ecall/Ebreak/halt_req, and hands the data-memory port to a debug
// requester while the core is idle or halted. Also keeps cycle and retired-instruction counts.
//   clk, rst             : clock, asynchronous active-low reset
//   start                : (re)boot pulse
//   halt_req             : external halt request (level)
//   step_req, resume     : single-step / continue pulses, honoured in HALT
//   Ecall, Ebreak        : trap decode from the core
//   core_we/addr/wdata   : core data-memory request
//   dbg_req/we/addr/wdata: debug data-memory request; dbg_gnt when it owns the port
//   mem_we/addr/wdata    : muxed data-memory request
//   core_rst, core_en    : core reset and execute enable
//   halted, halt_cause   : HALT indication and reason
//   cycle_cnt            : cycles with core_en high
//   instret_cnt          : retired non-trapping instructions
module core_run_ctrl
   import core_ctrl_pkg::*;
#(
   parameter int unsigned BOOT_CYCLES = 4,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned AW          = 32,
   parameter int unsigned DW          = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             halt_req,
   input  logic             step_req,
   input  logic             resume,
   input  logic             Ecall,
   input  logic             Ebreak,
   input  logic             core_we,
   input  logic [AW-1:0]    core_addr,
   input  logic [DW-1:0]    core_wdata,
   input  logic             dbg_req,
   input  logic             dbg_we,
   input  logic [AW-1:0]    dbg_addr,
   input  logic [DW-1:0]    dbg_wdata,
   output logic             dbg_gnt,
   output logic             mem_we,
   output logic [AW-1:0]    mem_addr,
   output logic [DW-1:0]    mem_wdata,
   output logic             core_rst,
   output logic             core_en,
   output logic             halted,
   output logic [2:0]       halt_cause,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   localparam int unsigned BootW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
   // Down-counter runs BOOT_CYCLES-1 .. 0, so BOOT lasts exactly BOOT_CYCLES cycles.
   localparam logic [BootW-1:0] BootLoad = BootW'(BOOT_CYCLES - 1);

   ctrl_state_e      state_q, state_d;
   halt_cause_e      cause_q, cause_d;
   logic [BootW-1:0] boot_q, boot_d;
   logic             cnt_clr;

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      boot_d  = boot_q;
      cnt_clr = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StBoot;
               boot_d  = BootLoad;
               cause_d = CauseNone;
               cnt_clr = 1'b1;
            end
         end
         StBoot: begin
            if (start) begin
               boot_d = BootLoad;
            end else if (boot_q == '0) begin
               state_d = StRun;
            end else begin
               boot_d = boot_q - BootW'(1);
            end
         end
         StRun: begin
            // Reboot from RUN keeps the counters running totals.
            if (start) begin
               state_d = StBoot;
               boot_d  = BootLoad;
            end else if (Ebreak) begin
               state_d = StHalt;
               cause_d = CauseEbreak;
            end else if (Ecall) begin
               state_d = StHalt;
               cause_d = CauseEcall;
            end else if (halt_req) begin
               state_d = StHalt;
               cause_d = CauseExt;
            end
         end
         StStep: begin
            state_d = StHalt;
            if (Ebreak) begin
               cause_d = CauseEbreak;
            end else if (Ecall) begin
               cause_d = CauseEcall;
            end else begin
               cause_d = CauseStep;
            end
         end
         StHalt: begin
            if (start) begin
               state_d = StBoot;
               boot_d  = BootLoad;
               cause_d = CauseNone;
               cnt_clr = 1'b1;
            end else if (step_req) begin
               state_d = StStep;
            end else if (resume) begin
               state_d = StRun;
               cause_d = CauseNone;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         cause_q <= CauseNone;
         boot_q  <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         boot_q  <= boot_d;
      end
   end

   // Moore outputs
   assign core_rst   = (state_q == StIdle) || (state_q == StBoot);
   assign core_en    = (state_q == StRun) || (state_q == StStep);
   assign halted     = (state_q == StHalt);
   assign halt_cause = cause_q;

   // Debug owns the memory port only while the core cannot be executing.
   always_comb begin
      dbg_gnt = dbg_req && ((state_q == StIdle) || (state_q == StHalt));
      if (dbg_gnt) begin
         mem_we    = dbg_we;
         mem_addr  = dbg_addr;
         mem_wdata = dbg_wdata;
      end else begin
         mem_we    = core_we & core_en;
         mem_addr  = core_addr;
         mem_wdata = core_wdata;
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_cycle_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (core_en),
      .q   (cycle_cnt)
   );

   sat_counter #(
      .W (CNT_W)
   ) u_instret_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (core_en & ~Ecall & ~Ebreak),
      .q   (instret_cnt)
   );

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl. A second instance with a 4-bit counter width shares the
// stimulus so saturation can be seen without preloading.
module tb_core_run_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, halt_req, step_req, resume, Ecall, Ebreak;
   logic        core_we, dbg_req, dbg_we;
   logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;

   logic        dbg_gnt, mem_we, core_rst, core_en, halted;
   logic [31:0] mem_addr, mem_wdata, cycle_cnt, instret_cnt;
   logic [2:0]  halt_cause;

   logic        s_dbg_gnt, s_mem_we, s_core_rst, s_core_en, s_halted;
   logic [31:0] s_mem_addr, s_mem_wdata;
   logic [2:0]  s_halt_cause;
   logic [3:0]  s_cycle_cnt, s_instret_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   core_run_ctrl #(
      .BOOT_CYCLES (4), .CNT_W (32), .AW (32), .DW (32)
   ) dut (
      .clk (clk), .rst (rst), .start (start), .halt_req (halt_req), .step_req (step_req),
      .resume (resume), .Ecall (Ecall), .Ebreak (Ebreak), .core_we (core_we),
      .core_addr (core_addr), .core_wdata (core_wdata), .dbg_req (dbg_req), .dbg_we (dbg_we),
      .dbg_addr (dbg_addr), .dbg_wdata (dbg_wdata), .dbg_gnt (dbg_gnt), .mem_we (mem_we),
      .mem_addr (mem_addr), .mem_wdata (mem_wdata), .core_rst (core_rst), .core_en (core_en),
      .halted (halted), .halt_cause (halt_cause), .cycle_cnt (cycle_cnt),
      .instret_cnt (instret_cnt)
   );

   core_run_ctrl #(
      .BOOT_CYCLES (4), .CNT_W (4), .AW (32), .DW (32)
   ) dut_small (
      .clk (clk), .rst (rst), .start (start), .halt_req (halt_req), .step_req (step_req),
      .resume (resume), .Ecall (Ecall), .Ebreak (Ebreak), .core_we (core_we),
      .core_addr (core_addr), .core_wdata (core_wdata), .dbg_req (dbg_req), .dbg_we (dbg_we),
      .dbg_addr (dbg_addr), .dbg_wdata (dbg_wdata), .dbg_gnt (s_dbg_gnt), .mem_we (s_mem_we),
      .mem_addr (s_mem_addr), .mem_wdata (s_mem_wdata), .core_rst (s_core_rst),
      .core_en (s_core_en), .halted (s_halted), .halt_cause (s_halt_cause),
      .cycle_cnt (s_cycle_cnt), .instret_cnt (s_instret_cnt)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      rst = 1'b0;
      {start, halt_req, step_req, resume, Ecall, Ebreak, core_we, dbg_req, dbg_we} = '0;
      core_addr = 32'd7; core_wdata = 32'd9; dbg_addr = '0; dbg_wdata = '0;
      #3;
      check("rst_core_rst", core_rst, 1);
      check("rst_core_en", core_en, 0);
      check("rst_halted", halted, 0);
      check("rst_cause", halt_cause, 0);
      check("rst_cycle", cycle_cnt, 0);
      check("rst_instret", instret_cnt, 0);
      tick(1);
      rst = 1'b1;
      tick(1);
      check("idle_core_rst", core_rst, 1);

      // Boot: four cycles in BOOT, then RUN.
      start = 1'b1;
      tick(1);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("boot_core_rst", core_rst, 1);
         check("boot_core_en", core_en, 0);
         tick(1);
      end
      check("run_core_rst", core_rst, 0);
      check("run_core_en", core_en, 1);
      check("run_cycle0", cycle_cnt, 0);
      tick(1);
      check("run_cycle1", cycle_cnt, 1);

      // Dbg request during RUN is ignored; core write passes through.
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'd100; dbg_wdata = 32'd25; core_we = 1'b1;
      #1;
      check("run_dbg_gnt", dbg_gnt, 0);
      check("run_mem_we", mem_we, 1);
      check("run_mem_addr", mem_addr, 7);
      check("run_mem_wdata", mem_wdata, 9);
      dbg_req = 1'b0; core_we = 1'b0;
      tick(9);

      // Eleventh run cycle traps on Ecall.
      Ecall = 1'b1;
      tick(1);
      Ecall = 1'b0;
      check("ecall_halted", halted, 1);
      check("ecall_cause", halt_cause, 1);
      check("ecall_cycle", cycle_cnt, 11);
      check("ecall_instret", instret_cnt, 10);
      check("ecall_core_en", core_en, 0);

      // Debug access in HALT.
      dbg_req = 1'b1; core_we = 1'b1;
      #1;
      check("halt_dbg_gnt", dbg_gnt, 1);
      check("halt_dbg_we", mem_we, 1);
      check("halt_dbg_addr", mem_addr, 100);
      check("halt_dbg_wdata", mem_wdata, 25);
      dbg_req = 1'b0;
      #1;
      check("halt_core_we_blocked", mem_we, 0);
      check("halt_core_addr", mem_addr, 7);

      // Single step.
      step_req = 1'b1;
      tick(1);
      step_req = 1'b0;
      check("step_core_en", core_en, 1);
      check("step_mem_we", mem_we, 1);
      dbg_req = 1'b1;
      #1;
      check("step_dbg_gnt", dbg_gnt, 0);
      dbg_req = 1'b0; core_we = 1'b0;
      tick(1);
      check("step_halted", halted, 1);
      check("step_core_en_off", core_en, 0);
      check("step_cause", halt_cause, 4);
      check("step_cycle", cycle_cnt, 12);
      check("step_instret", instret_cnt, 11);

      // Resume, then Ebreak and halt_req together: Ebreak wins.
      resume = 1'b1;
      tick(1);
      resume = 1'b0;
      check("resume_cause", halt_cause, 0);
      check("resume_core_en", core_en, 1);
      tick(1);
      Ebreak = 1'b1; halt_req = 1'b1;
      tick(1);
      Ebreak = 1'b0;
      check("ebreak_cause", halt_cause, 2);
      check("ebreak_cycle", cycle_cnt, 14);
      check("ebreak_instret", instret_cnt, 12);

      // Resume with halt_req still high: one RUN cycle, then EXT halt.
      resume = 1'b1;
      tick(1);
      resume = 1'b0;
      check("rehalt_run", core_en, 1);
      tick(1);
      halt_req = 1'b0;
      check("rehalt_halted", halted, 1);
      check("rehalt_cause", halt_cause, 3);
      check("rehalt_instret", instret_cnt, 13);
      check("sat_cycle_15", s_cycle_cnt, 15);

      // Run on, then reboot from RUN without clearing counters.
      resume = 1'b1;
      tick(1);
      resume = 1'b0;
      tick(2);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      check("reboot_core_rst", core_rst, 1);
      check("reboot_cycle", cycle_cnt, 18);
      check("reboot_instret", instret_cnt, 16);
      check("sat_cycle_held", s_cycle_cnt, 15);

      // start mid-BOOT restarts the count.
      tick(1);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(3);
      check("boot_restart_rst", core_rst, 1);
      check("boot_restart_en", core_en, 0);

      // Asynchronous reset mid-BOOT, between clock edges.
      #2 rst = 1'b0;
      #1;
      check("arst_cycle", cycle_cnt, 0);
      check("arst_instret", instret_cnt, 0);
      check("arst_core_rst", core_rst, 1);
      check("arst_halted", halted, 0);
      tick(1);
      rst = 1'b1;
      tick(6);
      check("arst_stays_idle", core_en, 0);
      check("arst_idle_rst", core_rst, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
- Run/halt sequencer for the single-cycle RISC-V core. It boots the core out of reset, gates execution with a clock-enable, and stops the core on Ecall, Ebreak or an external halt request.
- While the core is halted, it arbitrates the data-memory port between the core and a debug requester.
- Sits between top-level control (bench or debug host) and the core/dmem pair.
- Maintains cycle and retired-instruction counters.

Parameters:
- BOOT_CYCLES, 4, cycles core_rst is held after a start command (≥1)
- CNT_W, 32, width of cycle_cnt and instret_cnt
- AW, 32, data-memory address width
- DW, 32, data-memory data width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  pulse: (re)boot the core
- halt_req  in  1  external halt request
- step_req  in  1  pulse: execute exactly one instruction from HALT
- resume  in  1  pulse: continue from HALT without reboot
- Ecall  in  1  core decoded ECALL this cycle
- Ebreak  in  1  core decoded EBREAK this cycle
- core_we  in  1  core MemWrite
- core_addr  in  AW  core DataAddr
- core_wdata  in  DW  core WriteData
- dbg_req  in  1  debug memory access request
- dbg_we  in  1  debug write enable
- dbg_addr  in  AW  debug address
- dbg_wdata  in  DW  debug write data
- dbg_gnt  out  1  debug access granted this cycle
- mem_we  out  1  to dmem write enable
- mem_addr  out  AW  to dmem address
- mem_wdata  out  DW  to dmem write data
- core_rst  out  1  active-high reset to core
- core_en  out  1  core PC/regfile/state update enable
- halted  out  1  state is HALT
- halt_cause  out  3  0 NONE, 1 ECALL, 2 EBREAK, 3 EXT, 4 STEP
- cycle_cnt  out  CNT_W  cycles with core_en=1
- instret_cnt  out  CNT_W  retired non-trapping instructions

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, core_rst=1, core_en=0, halted=0, halt_cause=0, counters=0, boot counter=0.
  - Applies at any time, including mid-BOOT or mid-STEP.
- States: IDLE, BOOT, RUN, STEP, HALT. All outputs are Moore on state, except dbg_gnt and the mem_* mux, which are combinational.
- IDLE:
  - core_rst=1, core_en=0.
  - start → BOOT; counters and halt_cause cleared.
- BOOT:
  - core_rst=1, core_en=0.
  - Stays exactly BOOT_CYCLES cycles, then → RUN.
  - start during BOOT restarts the count.
- RUN:
  - core_rst=0, core_en=1.
  - Priority, evaluated each cycle: Ebreak → HALT cause 2; else Ecall → HALT cause 1; else halt_req → HALT cause 3; else stay.
  - The trapping instruction still executes that cycle (core_en=1), with cycle_cnt+1 and instret_cnt unchanged.
  - start in RUN → BOOT; counters are not cleared.
- STEP:
  - core_en=1 for exactly one cycle, then → HALT.
  - Cause is 2 or 1 if Ebreak/Ecall fired that cycle, else 4.
- HALT:
  - core_en=0, halted=1, halt_cause held.
  - Priority: start → BOOT (counters cleared) > step_req → STEP > resume → RUN (cause→0).
  - A halt_req still high on resume re-halts after one RUN cycle with cause 3.
- Memory arbitration:
  - dbg_gnt = dbg_req & (state ∈ {IDLE, HALT}).
  - If dbg_gnt: mem_* = dbg_* (mem_we=dbg_we).
  - Else: mem_addr/mem_wdata = core_*, mem_we = core_we & core_en.
  - A core write is never issued while core_en=0.
  - dbg_req outside IDLE/HALT is ignored (no grant, no queuing).
- Counters:
  - cycle_cnt increments on every core_en cycle.
  - instret_cnt increments on core_en & ~Ecall & ~Ebreak.
  - Both saturate at all-ones (no wrap).

Decomposition:
- core_ctrl_pkg holds:
  - typedef enum ctrl_state_e {IDLE, BOOT, RUN, STEP, HALT}
  - typedef enum logic [2:0] halt_cause_e, with values as listed
  - CAUSE_* constants
- Sub-module sat_counter (param W; inputs clk, rst, clr, inc; output q) is instantiated twice, plus a boot down-counter inline.

Test Plan:
- Reset, start, BOOT_CYCLES=4 → core_rst high for 4 cycles after start, core_en=1 on cycle 5; cycle_cnt=1 one cycle later.
- RUN 10 cycles, then Ecall=1 for one cycle → HALT next cycle, halt_cause=1, cycle_cnt=11, instret_cnt=10, core_en=0.
- In HALT: dbg_req=1, dbg_we=1, dbg_addr=100, dbg_wdata=25 → dbg_gnt=1, mem_we=1, mem_addr=100, mem_wdata=25. Same request in RUN → dbg_gnt=0, mem_* follow core.
- In HALT, step_req pulse → exactly one core_en cycle, instret_cnt+1, halt_cause=4. resume → RUN, halt_cause=0.
- RUN with Ebreak and halt_req in the same cycle → halt_cause=2. In HALT with core_we=1 → mem_we=0.
- rst low mid-BOOT → immediately (no clock) state IDLE, core_rst=1, counters 0. Counter preload near max → cycle_cnt saturates at 2^CNT_W−1.
